div_shift_sub: RTL

DIV_SHIFT_SUB -- requirements
Module: div_shift_sub

---
 rtl/div_shift_sub.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/div_shift_sub.sv
// div_shift_sub -- signed 2*DW / DW restoring shift-subtract divider.
//
// The divider accepts a request in IDLE. It runs 2*DW restoring iterations in
// CALC, one quotient bit per cycle, MSB first. FIX then applies the operand
// signs and the saturation and divide-by-zero rules. DONE presents a one-cycle
// done pulse. Results are registered on the edge entering DONE and hold until
// the next result.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   valid        start request, sampled only in IDLE
//   dividend     signed 2*DW-bit dividend
//   divisor      signed DW-bit divisor
//   busy         high in CALC, FIX and DONE
//   done         one-cycle result-valid pulse (high in DONE)
//   quotient     signed DW-bit quotient, truncated toward zero
//   remainder    signed DW-bit remainder, takes the dividend's sign
//   div_by_zero  divisor was zero
//   overflow     true quotient is outside the signed DW-bit range
module div_shift_sub #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [2*DW-1:0]   dividend,
  input  logic [DW-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     quotient,
  output logic [DW-1:0]     remainder,
  output logic              div_by_zero,
  output logic              overflow
);

  localparam int CW = $clog2(2*DW);

  // Largest magnitudes representable in a signed DW-bit quotient.
  localparam logic [2*DW-1:0] QPOS = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] QNEG = QPOS + 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic            sgn_a;
  logic            sgn_b;
  logic            dz;
  // The work register starts as |dividend|. It shifts left once per
  // iteration, and quotient bits enter at the bottom. After 2*DW iterations
  // it holds |quotient|.
  logic [2*DW-1:0] work;
  logic [DW-1:0]   dvs_mag;
  logic [DW:0]     prem;

  // Operand magnitudes at acceptance. |-2^(2*DW-1)| fits as unsigned.
  logic [2*DW-1:0] dvd_abs;
  logic [DW-1:0]   dvs_abs;

  // One restoring iteration.
  logic [DW+1:0]   trial;
  logic [DW+1:0]   diff;
  logic            fits;

  // Sign application and result selection.
  logic            neg;
  logic            ovf;
  logic [DW-1:0]   q_fix;
  logic [DW-1:0]   r_fix;
  logic [DW-1:0]   q_sel;
  logic [DW-1:0]   r_sel;

  always_comb begin
    dvd_abs = dividend[2*DW-1] ? (~dividend + 1'b1) : dividend;
    dvs_abs = divisor[DW-1]    ? (~divisor  + 1'b1) : divisor;
  end

  always_comb begin
    trial = {prem, work[2*DW-1]};
    diff  = trial - {2'b00, dvs_mag};
    fits  = ~diff[DW+1];
  end

  always_comb begin
    neg   = sgn_a ^ sgn_b;
    ovf   = neg ? (work > QNEG) : (work > QPOS);
    q_fix = neg   ? (~work[DW-1:0] + 1'b1)     : work[DW-1:0];
    r_fix = sgn_a ? (~prem[DW-1:0] + 1'b1)     : prem[DW-1:0];

    q_sel = q_fix;
    r_sel = r_fix;
    if (dz) begin
      q_sel = sgn_a ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      r_sel = '0;
    end else if (ovf) begin
      q_sel = neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      r_sel = '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (valid) state_nx = CALC;
      CALC: if (cnt == CW'(2*DW-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sgn_a   <= 1'b0;
      sgn_b   <= 1'b0;
      dz      <= 1'b0;
      work    <= '0;
      dvs_mag <= '0;
      prem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            cnt     <= '0;
            sgn_a   <= dividend[2*DW-1];
            sgn_b   <= divisor[DW-1];
            dz      <= (divisor == '0);
            work    <= dvd_abs;
            dvs_mag <= dvs_abs;
            prem    <= '0;
          end
        end
        CALC: begin
          cnt  <= cnt + 1'b1;
          prem <= fits ? diff[DW:0] : trial[DW:0];
          work <= {work[2*DW-2:0], fits};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == FIX) begin
      quotient    <= q_sel;
      remainder   <= r_sel;
      div_by_zero <= dz;
      overflow    <= ovf & ~dz;
    end
  end

endmodule
